alarm_trigger: RTL and testbench

- Consumes the alarm time and alarm-enable produced by the alarm-setting block, plus the running clock's current hours/minutes.
- Drives the buzzer when the current time matches the alarm time.
- Supports snooze with a bounded re-arm count, stop, and automatic ring timeout.
- Sits between the alarm-setting block, the timekeeping counter and the buzzer/LED outputs. Everything runs on the 1 Hz tick domain.

---
 rtl/alarm_trigger_if.sv | 52 +++++
 rtl/alarm_trigger.sv | 129 ++++++++++++
 tb/tb_alarm_trigger.sv | 225 ++++++++++++++++++++++
 3 files changed

// File: rtl/alarm_trigger_if.sv
// ---------------------------------------------------------------------------
// alarm_trigger_if
//
// Purpose: bundles the signals between the alarm-setting block, the
// timekeeping counter and the buzzer/LED side of alarm_trigger.
//
// Signal contract: there is no valid/ready handshake on this bus. Every
// input is a level that the trigger samples on each clk_1hz rising edge.
// Every output is a level that is valid from just after that edge until
// the next one.
//
// Signals:
//   cur_h, cur_m      current time from the timekeeping counter (6 bits each)
//   alarm_h, alarm_m  alarm time from the alarm-setting block (6 bits each)
//   alarm_en          alarm armed
//   snooze, stop      user requests, level sampled
//   buzzer            high while ringing
//   snoozing          high while a snooze interval runs
//   snooze_cnt        snoozes used in the current alarm event
//   state             FSM state (00 IDLE, 01 RINGING, 10 SNOOZED, 11 DONE)
//   ring_cnt          debug view of the ring-length counter
//   snz_timer         debug view of the snooze countdown
//
// Modports:
//   master  drives the time, alarm and request inputs (environment / bench)
//   slave   the alarm_trigger block itself
// ---------------------------------------------------------------------------
interface alarm_trigger_if;
    logic [5:0] cur_h;
    logic [5:0] cur_m;
    logic [5:0] alarm_h;
    logic [5:0] alarm_m;
    logic       alarm_en;
    logic       snooze;
    logic       stop;
    logic       buzzer;
    logic       snoozing;
    logic [3:0] snooze_cnt;
    logic [1:0] state;
    logic [6:0] ring_cnt;
    logic [9:0] snz_timer;

    modport master (
        output cur_h, cur_m, alarm_h, alarm_m, alarm_en, snooze, stop,
        input  buzzer, snoozing, snooze_cnt, state, ring_cnt, snz_timer
    );

    modport slave (
        input  cur_h, cur_m, alarm_h, alarm_m, alarm_en, snooze, stop,
        output buzzer, snoozing, snooze_cnt, state, ring_cnt, snz_timer
    );
endinterface

// File: rtl/alarm_trigger.sv
// ---------------------------------------------------------------------------
// alarm_trigger
//
// Purpose: compares the running time with the programmed alarm time and
// sounds the buzzer on a match. The user can snooze a bounded number of
// times or stop the alarm. Ringing also stops by itself after RING_SECONDS.
// Everything runs on the 1 Hz tick.
//
// Ports:
//   clk_1hz  1 Hz clock, rising edge
//   rst      asynchronous, active-high reset
//   bus      alarm_trigger_if.slave (inputs: time, alarm, enable, requests;
//            outputs: buzzer, snoozing, snooze_cnt, state, debug counters)
//
// Parameters:
//   RING_SECONDS    ticks the buzzer sounds before it stops itself (1..127)
//   SNOOZE_SECONDS  snooze interval in ticks (1..1023)
//   MAX_SNOOZE      snoozes allowed per alarm event (0..15)
// ---------------------------------------------------------------------------
module alarm_trigger #(
    parameter int RING_SECONDS   = 60,
    parameter int SNOOZE_SECONDS = 300,
    parameter int MAX_SNOOZE     = 3
) (
    input  logic                  clk_1hz,
    input  logic                  rst,
    alarm_trigger_if.slave        bus
);

    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        RINGING = 2'b01,
        SNOOZED = 2'b10,
        DONE    = 2'b11
    } state_t;

    localparam logic [6:0] RING_LAST  = 7'(RING_SECONDS - 1);
    localparam logic [9:0] SNZ_RELOAD = 10'(SNOOZE_SECONDS - 1);
    localparam logic [3:0] SNZ_MAX    = 4'(MAX_SNOOZE);

    state_t     state_q;
    logic [6:0] ring_cnt_q;
    logic [9:0] snz_timer_q;
    logic [3:0] snooze_cnt_q;
    logic       match;

    // Full-width compares: an out-of-range alarm value simply never matches.
    assign match = (bus.cur_h == bus.alarm_h) && (bus.cur_m == bus.alarm_m);

    // Single FSM. Priority on each edge: disable, then stop, then snooze,
    // then timeout / timer expiry. Each counter leaves its state at its
    // terminal value, so no counter ever wraps.
    always_ff @(posedge clk_1hz or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            ring_cnt_q   <= '0;
            snz_timer_q  <= '0;
            snooze_cnt_q <= '0;
        end else if (!bus.alarm_en) begin
            // Disarming cancels any alarm event, whatever the state.
            state_q      <= IDLE;
            ring_cnt_q   <= '0;
            snz_timer_q  <= '0;
            snooze_cnt_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    snooze_cnt_q <= '0;
                    if (match) begin
                        state_q    <= RINGING;
                        ring_cnt_q <= '0;
                    end
                end

                RINGING: begin
                    if (bus.stop) begin
                        state_q <= DONE;
                    end else if (bus.snooze && (snooze_cnt_q < SNZ_MAX)) begin
                        state_q      <= SNOOZED;
                        snz_timer_q  <= SNZ_RELOAD;
                        snooze_cnt_q <= snooze_cnt_q + 4'd1;
                    end else if (ring_cnt_q == RING_LAST) begin
                        // A snooze over the limit falls through to here, so
                        // the buzzer keeps going until the normal timeout.
                        state_q <= DONE;
                    end else begin
                        ring_cnt_q <= ring_cnt_q + 7'd1;
                    end
                end

                SNOOZED: begin
                    // The snooze input has no effect here. Expiry re-rings
                    // even after the alarm minute has passed.
                    if (bus.stop) begin
                        state_q <= DONE;
                    end else if (snz_timer_q == 10'd0) begin
                        state_q    <= RINGING;
                        ring_cnt_q <= '0;
                    end else begin
                        snz_timer_q <= snz_timer_q - 10'd1;
                    end
                end

                DONE: begin
                    // Hold until the alarm minute rolls over, so the same
                    // minute cannot retrigger.
                    if (!match) begin
                        state_q      <= IDLE;
                        snooze_cnt_q <= '0;
                    end
                end

                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    // Outputs are decoded straight from the state register, so they change
    // on the same edge as the transition.
    assign bus.buzzer     = (state_q == RINGING);
    assign bus.snoozing   = (state_q == SNOOZED);
    assign bus.state      = state_q;
    assign bus.snooze_cnt = snooze_cnt_q;
    assign bus.ring_cnt   = ring_cnt_q;
    assign bus.snz_timer  = snz_timer_q;

endmodule

// File: tb/tb_alarm_trigger.sv
// ---------------------------------------------------------------------------
// tb_alarm_trigger
//
// Purpose: directed test of alarm_trigger with its default parameters
// (60 s ring, 300 s snooze, 3 snoozes). Each expected value is worked out
// by hand from the alarm behaviour. Inputs change 1 ns after a rising edge,
// and outputs are checked at that same point.
// ---------------------------------------------------------------------------
module tb_alarm_trigger;

    logic clk_1hz;
    logic rst;
    int   errors;
    int   checks;

    alarm_trigger_if bus ();

    alarm_trigger #(
        .RING_SECONDS   (60),
        .SNOOZE_SECONDS (300),
        .MAX_SNOOZE     (3)
    ) dut (
        .clk_1hz (clk_1hz),
        .rst     (rst),
        .bus     (bus)
    );

    // ---------------- clock / reset ----------------
    initial clk_1hz = 1'b0;
    always #5 clk_1hz = ~clk_1hz;

    // ---------------- driver tasks ----------------
    task automatic tick(input int n);
        repeat (n) @(posedge clk_1hz);
        #1;
    endtask

    task automatic set_cur(input logic [5:0] h, input logic [5:0] m);
        bus.cur_h = h;
        bus.cur_m = m;
    endtask

    // ---------------- checker ----------------
    task automatic check_eq(input string tag, input logic [31:0] obs,
                            input logic [31:0] exp);
        checks = checks + 1;
        if (obs !== exp) begin
            errors = errors + 1;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    initial begin
        errors = 0;
        checks = 0;
        rst          = 1'b1;
        bus.alarm_h  = 6'd7;
        bus.alarm_m  = 6'd30;
        bus.alarm_en = 1'b1;
        bus.snooze   = 1'b0;
        bus.stop     = 1'b0;
        set_cur(6'd7, 6'd29);

        // Reset state
        tick(2);
        check_eq("rst_state", 32'(bus.state), 32'd0);
        check_eq("rst_buzzer", 32'(bus.buzzer), 32'd0);
        check_eq("rst_snoozing", 32'(bus.snoozing), 32'd0);
        check_eq("rst_snz_cnt", 32'(bus.snooze_cnt), 32'd0);
        #2 rst = 1'b0;

        // Hour mismatch with the minute matching must not ring
        set_cur(6'd8, 6'd30);
        tick(2);
        check_eq("hour_mismatch", 32'(bus.state), 32'd0);

        // ---- 1. basic ring and timeout ----
        set_cur(6'd7, 6'd29);
        tick(1);
        check_eq("t1_pre", 32'(bus.state), 32'd0);
        set_cur(6'd7, 6'd30);
        tick(1);
        check_eq("t1_ring_buzz", 32'(bus.buzzer), 32'd1);
        check_eq("t1_ring_state", 32'(bus.state), 32'd1);
        check_eq("t1_ring_cnt0", 32'(bus.ring_cnt), 32'd0);
        tick(59);
        check_eq("t1_last_buzz", 32'(bus.buzzer), 32'd1);
        check_eq("t1_last_cnt", 32'(bus.ring_cnt), 32'd59);
        tick(1);
        check_eq("t1_timeout", 32'(bus.state), 32'd3);
        check_eq("t1_timeout_bz", 32'(bus.buzzer), 32'd0);
        tick(5);
        check_eq("t1_hold_done", 32'(bus.state), 32'd3);
        set_cur(6'd7, 6'd31);
        tick(1);
        check_eq("t1_to_idle", 32'(bus.state), 32'd0);
        tick(2);
        check_eq("t1_no_ring", 32'(bus.buzzer), 32'd0);

        // ---- 2. stop on the 10th ring edge ----
        set_cur(6'd7, 6'd30);
        tick(1);                        // ring edge 1
        check_eq("t2_ring", 32'(bus.state), 32'd1);
        tick(8);                        // ring edges 2..9
        bus.stop = 1'b1;
        tick(1);                        // ring edge 10
        check_eq("t2_stop_state", 32'(bus.state), 32'd3);
        check_eq("t2_stop_buzz", 32'(bus.buzzer), 32'd0);
        bus.stop = 1'b0;
        tick(3);
        check_eq("t2_no_retrig", 32'(bus.state), 32'd3);
        set_cur(6'd7, 6'd31);
        tick(1);
        check_eq("t2_idle", 32'(bus.state), 32'd0);

        // ---- 3. snooze on the 5th ring edge ----
        set_cur(6'd7, 6'd30);
        tick(1);                        // ring edge 1
        tick(3);                        // ring edges 2..4
        bus.snooze = 1'b1;
        tick(1);                        // ring edge 5
        check_eq("t3_snoozing", 32'(bus.snoozing), 32'd1);
        check_eq("t3_snz_cnt", 32'(bus.snooze_cnt), 32'd1);
        check_eq("t3_buzz_off", 32'(bus.buzzer), 32'd0);
        check_eq("t3_timer", 32'(bus.snz_timer), 32'd299);
        bus.snooze = 1'b0;
        set_cur(6'd7, 6'd35);
        tick(299);
        check_eq("t3_still_snz", 32'(bus.snoozing), 32'd1);
        check_eq("t3_timer0", 32'(bus.snz_timer), 32'd0);
        tick(1);
        check_eq("t3_rering", 32'(bus.buzzer), 32'd1);
        check_eq("t3_ring_cnt0", 32'(bus.ring_cnt), 32'd0);
        check_eq("t3_cnt_kept", 32'(bus.snooze_cnt), 32'd1);

        // ---- 4. snooze limit ----
        bus.snooze = 1'b1;
        tick(1);
        check_eq("t4_snz2", 32'(bus.snooze_cnt), 32'd2);
        tick(5);                        // snooze held while SNOOZED: ignored
        check_eq("t4_ign_state", 32'(bus.state), 32'd2);
        check_eq("t4_ign_cnt", 32'(bus.snooze_cnt), 32'd2);
        check_eq("t4_ign_timer", 32'(bus.snz_timer), 32'd294);
        bus.snooze = 1'b0;
        tick(295);
        check_eq("t4_ring2", 32'(bus.state), 32'd1);
        bus.snooze = 1'b1;
        tick(1);
        check_eq("t4_snz3", 32'(bus.snooze_cnt), 32'd3);
        bus.snooze = 1'b0;
        tick(300);
        check_eq("t4_ring3", 32'(bus.state), 32'd1);
        bus.snooze = 1'b1;
        tick(1);                        // fourth snooze is over the limit
        check_eq("t4_over_state", 32'(bus.state), 32'd1);
        check_eq("t4_over_cnt", 32'(bus.snooze_cnt), 32'd3);
        check_eq("t4_over_ring", 32'(bus.ring_cnt), 32'd1);
        tick(58);
        check_eq("t4_buzz_59", 32'(bus.buzzer), 32'd1);
        tick(1);
        check_eq("t4_timeout", 32'(bus.state), 32'd3);
        bus.snooze = 1'b0;
        tick(1);                        // cur is 07:35, so DONE leaves at once
        check_eq("t4_idle", 32'(bus.state), 32'd0);
        check_eq("t4_cnt_clr", 32'(bus.snooze_cnt), 32'd0);

        // ---- 5A. disable while SNOOZED ----
        set_cur(6'd7, 6'd30);
        tick(1);
        bus.snooze = 1'b1;
        tick(1);
        bus.snooze = 1'b0;
        check_eq("t5a_snoozed", 32'(bus.state), 32'd2);
        tick(10);
        bus.alarm_en = 1'b0;
        tick(1);
        check_eq("t5a_idle", 32'(bus.state), 32'd0);
        check_eq("t5a_cnt0", 32'(bus.snooze_cnt), 32'd0);
        tick(1);
        check_eq("t5a_disabled", 32'(bus.buzzer), 32'd0);

        // ---- 5B. stop and snooze together ----
        bus.alarm_en = 1'b1;
        tick(1);                        // still 07:30: fresh match from IDLE
        check_eq("t5b_ring", 32'(bus.state), 32'd1);
        bus.snooze = 1'b1;
        tick(1);
        bus.snooze = 1'b0;
        tick(300);
        check_eq("t5b_ring2", 32'(bus.state), 32'd1);
        bus.stop   = 1'b1;
        bus.snooze = 1'b1;
        tick(1);
        check_eq("t5b_done", 32'(bus.state), 32'd3);
        check_eq("t5b_cnt", 32'(bus.snooze_cnt), 32'd1);
        bus.stop   = 1'b0;
        bus.snooze = 1'b0;
        set_cur(6'd7, 6'd31);
        tick(1);
        check_eq("t5b_idle", 32'(bus.state), 32'd0);

        // ---- 6. asynchronous reset mid-ring ----
        set_cur(6'd7, 6'd30);
        tick(1);
        bus.snooze = 1'b1;
        tick(1);
        bus.snooze = 1'b0;
        tick(300);
        check_eq("t6_ring", 32'(bus.buzzer), 32'd1);
        check_eq("t6_cnt1", 32'(bus.snooze_cnt), 32'd1);
        #2 rst = 1'b1;                  // between edges
        #1;
        check_eq("t6_rst_buzz", 32'(bus.buzzer), 32'd0);
        check_eq("t6_rst_state", 32'(bus.state), 32'd0);
        check_eq("t6_rst_cnt", 32'(bus.snooze_cnt), 32'd0);
        #1 rst = 1'b0;
        check_eq("t6_rel_state", 32'(bus.state), 32'd0);
        tick(1);
        check_eq("t6_fresh_ring", 32'(bus.state), 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
